// File: rtl/spi_txn_arbiter_pkg.sv
// spi_arb_pkg: shared state encoding and sizing helpers for spi_txn_arbiter
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} arb_state_t;
  localparam int GAP_CYCLES = 1;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: requester, driver and read-stream signals of the arbiter
// slave modport = arbiter side, master modport = requesters plus SPI driver
interface spi_txn_arbiter_if import spi_arb_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int REG_WIDTH = 8
);
  localparam int IW = id_w(NUM_REQ);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_is_write;
  logic [NUM_REQ*8-1:0]         req_num_regs;
  logic [NUM_REQ*REG_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_done;
  logic                         req_err;
  logic                         drv_new_command;
  logic                         drv_is_write;
  logic [7:0]                   drv_num_regs;
  logic [REG_WIDTH-1:0]         drv_start_addr;
  logic                         drv_read_complete;
  logic                         drv_write_complete;
  logic                         drv_byte_valid;
  logic [REG_WIDTH-1:0]         drv_byte_data;
  logic                         rd_valid;
  logic [REG_WIDTH-1:0]         rd_data;
  logic [IW-1:0]                rd_id;
  modport slave (
    input  req_valid, req_is_write, req_num_regs, req_addr,
           drv_read_complete, drv_write_complete, drv_byte_valid, drv_byte_data,
    output req_ready, req_done, req_err, drv_new_command, drv_is_write,
           drv_num_regs, drv_start_addr, rd_valid, rd_data, rd_id
  );
  modport master (
    output req_valid, req_is_write, req_num_regs, req_addr,
           drv_read_complete, drv_write_complete, drv_byte_valid, drv_byte_data,
    input  req_ready, req_done, req_err, drv_new_command, drv_is_write,
           drv_num_regs, drv_start_addr, rd_valid, rd_data, rd_id
  );
endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rr_pick: first asserted request after i_ptr (wrapping) -> one-hot grant, found flag, id
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_found,
  output logic [IW-1:0] o_id
);
  always_comb begin
    o_found = 1'b0;
    o_id = '0;
    for (int k = 1; k <= N; k++)
      if (!o_found && i_req[(int'(i_ptr) + k) % N]) begin
        o_found = 1'b1;
        o_id = IW'((int'(i_ptr) + k) % N);
      end
    o_grant = o_found ? N'(1) << o_id : '0;
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI read/write driver among NUM_REQ requesters
// Ports: clk, rstn (async active-low), bus (spi_txn_arbiter_if.slave: requests,
// ready/done/err pulses, latched drv_* command, driver completions, tagged read bytes).
// Optional SPI_ARB_TIMEOUT_EN: WAIT_DONE watchdog of TIMEOUT_CYCLES cycles.
module spi_txn_arbiter import spi_arb_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int REG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rstn,
  spi_txn_arbiter_if.slave bus
);
  localparam int IW = id_w(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8) $error("NUM_REQ must be 2..8");
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) $error("TIMEOUT_CYCLES must be 1..65536");
  arb_state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_id, w_id;
  logic [NUM_REQ-1:0] w_grant, w_ready, w_done, r_ready, r_done;
  logic w_found, w_take, w_fin, w_zero, w_cmplt, w_tmo, w_err, w_rd;
  logic r_err, r_wr, r_rd_valid;
  logic [7:0] r_num;
  logic [REG_WIDTH-1:0] r_addr, r_rd_data;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req(bus.req_valid), .i_ptr(r_ptr), .o_grant(w_grant), .o_found(w_found), .o_id(w_id)
  );
  // a zero count would underflow the driver, so it is answered here with an error
  assign w_zero = bus.req_num_regs[8*int'(w_id) +: 8] == 8'd0;
  // only the completion matching the granted transaction type counts
  assign w_cmplt = r_wr ? bus.drv_write_complete : bus.drv_read_complete;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else if (r_state == ISSUE) r_cnt <= '0;
    else if (r_state == WAIT_DONE) r_cnt <= r_cnt + 16'd1;
  assign w_tmo = r_state == WAIT_DONE && r_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_found) w_next = w_zero ? GAP : ISSUE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: if (w_cmplt || w_tmo) w_next = GAP;
      GAP:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_take = r_state == IDLE && w_found;
    w_fin = r_state == WAIT_DONE && (w_cmplt || w_tmo);
    w_ready = w_take ? w_grant : '0;
    w_done = (w_take && w_zero) ? w_grant : w_fin ? NUM_REQ'(1) << r_id : '0;
    w_err = (w_take && w_zero) || (w_fin && !w_cmplt);
    w_rd = bus.drv_byte_valid && !r_wr && (r_state == WAIT_DONE || r_state == GAP);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_ptr <= IW'(NUM_REQ - 1);
      r_id <= '0;
      r_wr <= 1'b0;
      r_num <= '0;
      r_addr <= '0;
      r_ready <= '0;
      r_done <= '0;
      r_err <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ready <= w_ready;
      r_done <= w_done;
      r_err <= w_err;
      r_rd_valid <= w_rd;
      r_rd_data <= bus.drv_byte_data;
      if (w_take) begin
        r_ptr <= w_id;
        r_id <= w_id;
        r_wr <= bus.req_is_write[w_id];
        r_num <= bus.req_num_regs[8*int'(w_id) +: 8];
        r_addr <= bus.req_addr[REG_WIDTH*int'(w_id) +: REG_WIDTH];
      end
    end
  assign bus.req_ready = r_ready;
  assign bus.req_done = r_done;
  assign bus.req_err = r_err;
  assign bus.drv_new_command = r_state == ISSUE;
  assign bus.drv_is_write = r_wr;
  assign bus.drv_num_regs = r_num;
  assign bus.drv_start_addr = r_addr;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_id = r_id;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: randomized self-checking bench with a requester/driver reference model
module tb_spi_txn_arbiter;
  import spi_arb_pkg::*;
  localparam int N = 2, RW = 8, TO = 16;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  spi_txn_arbiter_if #(.NUM_REQ(N), .REG_WIDTH(RW)) bus();
  spi_txn_arbiter #(.NUM_REQ(N), .REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  typedef struct {int id; bit wr; int num; int addr;} cmd_t;
  cmd_t q_cmd[$];
  int q_exp_rd[$], q_rd[$], q_done[$];
  int tests = 0, fails = 0, cyc = 0, n_cmd = 0, last_done = -100, m_last = N - 1;
  bit drv_auto = 1'b0, act = 1'b0;
  logic [RW+8:0] snap;

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rstn) act = 1'b0;
    else begin
      if (bus.rd_valid) q_rd.push_back(int'(bus.rd_id) * 256 + int'(bus.rd_data));
      if (act) begin
        tests++;
        if ({bus.drv_is_write, bus.drv_num_regs, bus.drv_start_addr} !== snap) begin
          fails++;
          $display("FAIL fields_stable: got %h required %h", {bus.drv_is_write, bus.drv_num_regs, bus.drv_start_addr}, snap);
        end
      end
      if (bus.req_done != 0) begin
        q_done.push_back(oh2i(bus.req_done) + 100 * int'(bus.req_err));
        last_done = cyc;
        act = 1'b0;
      end
      if (bus.drv_new_command) begin
        n_cmd++;
        tests++;
        if (cyc - last_done < GAP_CYCLES + 1) begin
          fails++;
          $display("FAIL cmd_gap: got %0d cycles after done, required >= %0d", cyc - last_done, GAP_CYCLES + 1);
        end
        act = 1'b1;
        snap = {bus.drv_is_write, bus.drv_num_regs, bus.drv_start_addr};
      end
    end
  end

  initial begin
    cmd_t e;
    int d;
    forever begin
      @(negedge clk);
      if (drv_auto && rstn && bus.drv_new_command) begin
        tests++;
        if (q_cmd.size() == 0) begin
          fails++;
          $display("FAIL unexpected_cmd: got a command, required none");
        end else begin
          e = q_cmd.pop_front();
          if (bus.drv_is_write !== e.wr || bus.drv_num_regs !== 8'(e.num) || bus.drv_start_addr !== RW'(e.addr)) begin
            fails++;
            $display("FAIL cmd_fields: got wr=%0b n=%0d a=%h required wr=%0b n=%0d a=%h",
                     bus.drv_is_write, bus.drv_num_regs, bus.drv_start_addr, e.wr, e.num, e.addr);
          end
          if (!e.wr)
            for (int b = 0; b < e.num; b++) begin
              repeat (1 + $urandom_range(0, 1)) @(negedge clk);
              d = $urandom_range(0, 255);
              bus.drv_byte_valid = 1'b1;
              bus.drv_byte_data = RW'(d);
              q_exp_rd.push_back(e.id * 256 + d);
              @(negedge clk);
              bus.drv_byte_valid = 1'b0;
            end
          repeat (1 + $urandom_range(0, 3)) @(negedge clk);
          if (e.wr) bus.drv_write_complete = 1'b1;
          else bus.drv_read_complete = 1'b1;
          @(negedge clk);
          bus.drv_write_complete = 1'b0;
          bus.drv_read_complete = 1'b0;
        end
      end
    end
  end

  task automatic set_fields(input int id, input bit wr, input int num, input int addr);
    bus.req_is_write[id] = wr;
    bus.req_num_regs[8*id +: 8] = 8'(num);
    bus.req_addr[RW*id +: RW] = RW'(addr);
  endtask

  task automatic check_rd(input string name);
    bit ok;
    ok = q_rd.size() == q_exp_rd.size();
    for (int i = 0; i < q_rd.size(); i++) if (ok && q_rd[i] != q_exp_rd[i]) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d bytes (first %0h), required %0d bytes (first %0h)", name, q_rd.size(),
               q_rd.size() ? q_rd[0] : -1, q_exp_rd.size(), q_exp_rd.size() ? q_exp_rd[0] : -1);
    end
    q_rd.delete();
    q_exp_rd.delete();
  endtask

  task automatic wait_ready(output int g);
    int t = 0;
    g = -1;
    while (g < 0 && t < 300) begin
      @(negedge clk);
      t++;
      if (bus.req_ready != 0) g = oh2i(bus.req_ready);
    end
  endtask

  task automatic run_one(input int id, input bit wr, input int num, input int addr);
    int g, t;
    if (num != 0) q_cmd.push_back('{id, wr, num, addr});
    set_fields(id, wr, num, addr);
    bus.req_valid[id] = 1'b1;
    wait_ready(g);
    tests++;
    if (g != id) begin
      fails++;
      $display("FAIL ready: got %0d required %0d", g, id);
    end
    bus.req_valid[id] = 1'b0;
    m_last = id;
    if (num == 0) begin
      tests++;
      if (bus.req_done !== N'(1 << id) || bus.req_err !== 1'b1) begin
        fails++;
        $display("FAIL zero_done: got done=%b err=%b required done=%b err=1", bus.req_done, bus.req_err, N'(1 << id));
      end
    end
    t = 0;
    while (q_done.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (q_done.size() != 1 || q_done[0] != id + (num == 0 ? 100 : 0)) begin
      fails++;
      $display("FAIL done: got %0d entries (first %0d) required 1 entry %0d", q_done.size(),
               q_done.size() ? q_done[0] : -1, id + (num == 0 ? 100 : 0));
    end
    q_done.delete();
    check_rd("rd_stream");
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests += 4;
    if (bus.req_ready !== '0 || bus.req_done !== '0 || bus.req_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_req: got ready=%b done=%b err=%b required 0", bus.req_ready, bus.req_done, bus.req_err);
    end
    if (bus.drv_new_command !== 1'b0 || bus.drv_is_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_drv: got cmd=%b wr=%b required 0", bus.drv_new_command, bus.drv_is_write);
    end
    if (bus.drv_num_regs !== '0 || bus.drv_start_addr !== '0) begin
      fails++;
      $display("FAIL reset_fields: got n=%h a=%h required 0", bus.drv_num_regs, bus.drv_start_addr);
    end
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.rd_id !== '0) begin
      fails++;
      $display("FAIL reset_rd: got v=%b d=%h id=%h required 0", bus.rd_valid, bus.rd_data, bus.rd_id);
    end
    rstn = 1'b1;
    m_last = N - 1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.drv_new_command !== 1'b0 || bus.req_ready !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got cmd=%b ready=%b required 0", bus.drv_new_command, bus.req_ready);
    end
    drv_auto = 1'b1;
  endtask

  task automatic test_single_read;
    int n0 = n_cmd;
    run_one(0, 1'b0, 2, 'h10);
    tests++;
    if (n_cmd != n0 + 1) begin
      fails++;
      $display("FAIL single_cmd_count: got %0d required %0d", n_cmd - n0, 1);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      run_one($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 255));
  endtask

  task automatic test_contention(input int n);
    int ids[16], kn[16], ka[16];
    bit kw[16];
    int g, t;
    for (int k = 0; k < n; k++) begin
      ids[k] = (m_last + 1 + k) % N;
      kw[k] = 1'($urandom_range(0, 1));
      kn[k] = $urandom_range(1, 3);
      ka[k] = $urandom_range(0, 255);
      q_cmd.push_back('{ids[k], kw[k], kn[k], ka[k]});
    end
    for (int k = 0; k < 2 && k < n; k++) begin
      set_fields(ids[k], kw[k], kn[k], ka[k]);
      bus.req_valid[ids[k]] = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      wait_ready(g);
      tests++;
      if (g != ids[k]) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %0d required %0d", k, g, ids[k]);
      end
      if (k + 2 < n) set_fields(ids[k+2], kw[k+2], kn[k+2], ka[k+2]);
      else bus.req_valid[ids[k]] = 1'b0;
    end
    m_last = ids[n-1];
    t = 0;
    while (q_done.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < n; k++) begin
      tests++;
      if (k >= q_done.size() || q_done[k] != ids[k]) begin
        fails++;
        $display("FAIL rr_done[%0d]: got %0d required %0d", k, k < q_done.size() ? q_done[k] : -1, ids[k]);
      end
    end
    q_done.delete();
    check_rd("contention_rd");
  endtask

  task automatic test_zero_length;
    int n0 = n_cmd;
    run_one(1, 1'b0, 0, 'h55);
    repeat (4) @(negedge clk);
    tests++;
    if (n_cmd != n0) begin
      fails++;
      $display("FAIL zero_no_cmd: got %0d commands required 0", n_cmd - n0);
    end
  endtask

  task automatic test_mismatch;
    int g;
    drv_auto = 1'b0;
    set_fields(0, 1'b1, 1, 'h33);
    bus.req_valid[0] = 1'b1;
    wait_ready(g);
    bus.req_valid[0] = 1'b0;
    m_last = 0;
    tests++;
    if (g != 0 || bus.drv_new_command !== 1'b1 || bus.drv_is_write !== 1'b1 || bus.drv_start_addr !== 8'h33) begin
      fails++;
      $display("FAIL mm_issue: got g=%0d cmd=%b wr=%b a=%h required g=0 cmd=1 wr=1 a=33", g,
               bus.drv_new_command, bus.drv_is_write, bus.drv_start_addr);
    end
    repeat (2) @(negedge clk);
    bus.drv_read_complete = 1'b1;
    @(negedge clk);
    bus.drv_read_complete = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (q_done.size() != 0) begin
      fails++;
      $display("FAIL mm_ignored: got %0d done pulses required 0", q_done.size());
    end
    bus.drv_write_complete = 1'b1;
    @(negedge clk);
    bus.drv_write_complete = 1'b0;
    tests++;
    if (bus.req_done !== 2'b01 || bus.req_err !== 1'b0) begin
      fails++;
      $display("FAIL mm_done: got done=%b err=%b required 01/0", bus.req_done, bus.req_err);
    end
    repeat (3) @(negedge clk);
    q_done.delete();
    drv_auto = 1'b1;
  endtask

  task automatic test_timeout;
    int g, t;
    drv_auto = 1'b0;
    set_fields(1, 1'b0, 3, 'h44);
    bus.req_valid[1] = 1'b1;
    wait_ready(g);
    bus.req_valid[1] = 1'b0;
    m_last = 1;
`ifdef SPI_ARB_TIMEOUT_EN
    t = 0;
    while (bus.req_done == 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t != TO + 1 || bus.req_done !== 2'b10 || bus.req_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout: got t=%0d done=%b err=%b required t=%0d done=10 err=1", t, bus.req_done, bus.req_err, TO + 1);
    end
    bus.drv_read_complete = 1'b1;
    @(negedge clk);
    bus.drv_read_complete = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (q_done.size() != 1) begin
      fails++;
      $display("FAIL timeout_stray: got %0d done pulses required 1", q_done.size());
    end
`else
    t = 0;
    repeat (40) @(negedge clk);
    tests++;
    if (q_done.size() != 0) begin
      fails++;
      $display("FAIL no_timeout: got %0d done pulses required 0", q_done.size());
    end
    bus.drv_read_complete = 1'b1;
    @(negedge clk);
    bus.drv_read_complete = 1'b0;
    tests++;
    if (bus.req_done !== 2'b10 || bus.req_err !== 1'b0) begin
      fails++;
      $display("FAIL late_done: got done=%b err=%b required 10/0 (t=%0d)", bus.req_done, bus.req_err, t);
    end
    repeat (3) @(negedge clk);
`endif
    q_done.delete();
    drv_auto = 1'b1;
    run_one(0, 1'b0, 1, 'h21);
  endtask

  task automatic test_reset_mid;
    int g;
    drv_auto = 1'b0;
    set_fields(0, 1'b0, 2, 'h66);
    bus.req_valid[0] = 1'b1;
    wait_ready(g);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    tests++;
    if ({bus.req_ready, bus.req_done, bus.req_err, bus.drv_new_command, bus.drv_is_write,
         bus.drv_num_regs, bus.drv_start_addr, bus.rd_valid} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got ready=%b done=%b err=%b n=%h a=%h required 0",
               bus.req_ready, bus.req_done, bus.req_err, bus.drv_num_regs, bus.drv_start_addr);
    end
    @(negedge clk);
    rstn = 1'b1;
    m_last = N - 1;
    repeat (3) @(negedge clk);
    tests++;
    if (q_done.size() != 0) begin
      fails++;
      $display("FAIL mid_reset_no_done: got %0d done pulses required 0", q_done.size());
    end
    drv_auto = 1'b1;
    test_contention(2);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_is_write = '0;
    bus.req_num_regs = '0;
    bus.req_addr = '0;
    bus.drv_read_complete = 1'b0;
    bus.drv_write_complete = 1'b0;
    bus.drv_byte_valid = 1'b0;
    bus.drv_byte_data = '0;
    test_reset;
    test_single_read;
    test_random;
    test_contention(6);
    test_zero_length;
    test_mismatch;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI driver (read path plus write path, common `new_command` / `is_write` / `num_regs` / start-address interface) between NUM_REQ command sources, e.g. the host register bridge and a periodic readback scheduler.
- Round-robin arbitration. Launches one transaction at a time with a clean `new_command` rising edge and holds the command fields stable until the driver reports completion.
- Returns per-requester done/error pulses and a tagged read-byte stream.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REG_WIDTH, 8, register address/data width; must match the driver.
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; also drives the SPI driver.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until that requester's req_ready.
- req_is_write  in  NUM_REQ  1 = write transaction, 0 = read.
- req_num_regs  in  NUM_REQ*8  register count, packed, requester i at [8i+7:8i].
- req_addr  in  NUM_REQ*REG_WIDTH  start register address, packed.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_err  out  1  qualifies req_done: 1 = rejected or timed out.
- drv_new_command  out  1  command strobe to the driver.
- drv_is_write  out  1  latched transaction type.
- drv_num_regs  out  8  latched count.
- drv_start_addr  out  REG_WIDTH  latched address.
- drv_read_complete  in  1  driver read-done pulse.
- drv_write_complete  in  1  driver write-done pulse.
- drv_byte_valid  in  1  driver read-byte pulse.
- drv_byte_data  in  REG_WIDTH  driver read byte.
- rd_valid  out  1  forwarded byte strobe.
- rd_data  out  REG_WIDTH  forwarded byte.
- rd_id  out  $clog2(NUM_REQ) (minimum 1)  owner of the current byte.

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first. Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Picks the first asserted req_valid searching from pointer+1, with wrap-around.
  - Registers is_write, num_regs and addr into the drv_* outputs and the grant id.
  - Pulses req_ready[id] and updates the pointer to id.
  - Next state: ISSUE, or GAP if num_regs==0.
  - Latency: req_valid seen at edge n -> req_ready and drv fields valid after edge n+1.
- Zero-length request:
  - No driver command is issued.
  - req_done[id] and req_err are pulsed on the GAP entry cycle.
  - The driver arithmetic underflows on a count of 0, so this case is never forwarded.
- ISSUE:
  - drv_new_command = 1 for exactly one cycle, one cycle after the fields are stable.
  - Next state: WAIT_DONE.
- WAIT_DONE:
  - drv_new_command = 0.
  - Read: complete on drv_read_complete.
  - Write: complete on drv_write_complete.
  - A completion pulse of the wrong type is ignored.
  - On completion: req_done[id] pulses with req_err=0 in the next cycle; next state GAP.
- GAP:
  - Exactly one cycle, guaranteeing new_command is low for at least 2 cycles between commands and the driver is back in its idle state.
  - Then IDLE.
- drv_* fields: change only in IDLE on a grant; stable through ISSUE/WAIT_DONE/GAP.
- Read forwarding:
  - rd_valid/rd_data are drv_byte_valid/drv_byte_data registered by one cycle, gated by (state==WAIT_DONE or GAP) and a read grant.
  - rd_id = grant id.
  - Bytes outside a read transaction are dropped.
- Simultaneous requests resolve by RR. A requester dropping req_valid before grant is legal. A requester reasserting immediately after its done waits behind the others.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - 16-bit cycle counter cleared on ISSUE.
  - In WAIT_DONE at count == TIMEOUT_CYCLES-1: req_done[id] and req_err pulse, next state GAP.
  - A later stray driver completion is ignored.
- Undefined: no counter; WAIT_DONE waits indefinitely; req_err asserts only for zero-length requests.

Decomposition:
- spi_arb_pkg:
  - arb_state_t enum (2-bit).
  - ID_W function/constant.
  - GAP_CYCLES=1.
- Sub-module rr_pick, combinational: req vector + pointer -> one-hot grant, found flag, encoded id. Instantiated once.

Test Plan:
- Single read: req0 valid, num_regs=2, addr=0x10 -> one new_command pulse; 2 rd_valid with rd_id=0; req_done[0]=1, req_err=0; next command no earlier than 2 cycles after done.
- Contention: req0 and req1 held continuously (NUM_REQ=2) -> grants alternate 0,1,0,1; drv fields never change during WAIT_DONE.
- Zero-length: req1 num_regs=0 -> drv_new_command stays 0; req_done[1]=1 with req_err=1 two cycles after req_valid.
- Mismatched completion: write grant, drv_read_complete pulse -> no req_done; a subsequent drv_write_complete -> req_done.
- Reset during WAIT_DONE: rstn low for 1 cycle -> all outputs 0; no req_done; req0 granted first after release.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, driver silent -> req_done with req_err=1 at 16 cycles after ISSUE; arbiter returns to IDLE.
